// File: rtl/font_rom_arbiter.sv
// ----------------------------------------------------------------------------
// font_rom_arbiter
//
// Lets two glyph-fetch requesters share a single font_rom. Port 0 is the HUD
// text renderer and port 1 is the end-screen text renderer.
//
// How it works:
//   - Requests are arbitrated round-robin, with at most one ROM grant per
//     clock.
//   - Each granted read carries an owner tag down a pipeline. The pipeline is
//     as long as the ROM read latency, so the tag and rom_data arrive together.
//   - Returned glyph data is registered per port, along with a one-cycle ack.
//
// Handshake:
//   A requester raises reqN with addrN and holds addrN stable until ackN
//   pulses. dataN is valid in the ackN cycle and holds until the next ackN.
//   If reqN is still high in the ackN cycle, that counts as a new request.
//
// Parameters:
//   ADDR_W   font ROM address width ({char_code[6:0], char_line[3:0]})
//   DATA_W   glyph line width
//   ROM_LAT  font_rom read latency in clocks (1..4)
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   req0/addr0          port 0 request and glyph address
//   ack0/data0          port 0 return pulse and held glyph line
//   req1/addr1          port 1 request and glyph address
//   ack1/data1          port 1 return pulse and held glyph line
//   rom_addr            registered address to font_rom
//   rom_data            font_rom read data, ROM_LAT clocks after rom_addr
//
// Optional feature (macro FONT_ARB_CACHE_EN):
//   Each port gets a one-entry last-hit cache. A repeat of the last fetched
//   address is answered on the next edge and does not use the ROM.
// ----------------------------------------------------------------------------
module font_rom_arbiter #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              ack0,
    output logic [DATA_W-1:0] data0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack1,
    output logic [DATA_W-1:0] data1,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    // One outstanding read per port.
    logic pend0;
    logic pend1;

    // Owner of the most recent ROM grant. Reset value 1 gives port 0 the
    // first contended grant.
    logic last_gnt;

    // Tag pipe: stage k holds the grant from k+1 edges ago. The last stage,
    // index ROM_LAT, lines up with rom_data for that grant.
    logic [ROM_LAT:0] tag_valid;
    logic [ROM_LAT:0] tag_owner;

    logic elig0;
    logic elig1;
    logic hit0;
    logic hit1;
    logic arb0;
    logic arb1;
    logic gnt_any;
    logic gnt_port;
    logic ret_valid;
    logic ret_owner;

    assign elig0     = req0 && !pend0;
    assign elig1     = req1 && !pend1;
    assign ret_valid = tag_valid[ROM_LAT];
    assign ret_owner = tag_owner[ROM_LAT];

`ifdef FONT_ARB_CACHE_EN
    logic              cvalid0;
    logic              cvalid1;
    logic [ADDR_W-1:0] caddr0;
    logic [ADDR_W-1:0] caddr1;
    logic [DATA_W-1:0] cdata0;
    logic [DATA_W-1:0] cdata1;
    // Address each port was granted with. rom_addr cannot serve this purpose
    // because the other port's grant may overwrite it while this read is
    // still in flight.
    logic [ADDR_W-1:0] gaddr0;
    logic [ADDR_W-1:0] gaddr1;

    assign hit0 = elig0 && cvalid0 && (addr0 == caddr0);
    assign hit1 = elig1 && cvalid1 && (addr1 == caddr1);
`else
    assign hit0 = 1'b0;
    assign hit1 = 1'b0;
`endif

    // Round-robin choice among the ports that actually need the ROM.
    always_comb begin
        arb0     = elig0 && !hit0;
        arb1     = elig1 && !hit1;
        gnt_any  = arb0 || arb1;
        gnt_port = 1'b0;
        if (arb0 && arb1) begin
            gnt_port = !last_gnt;
        end else if (arb1) begin
            gnt_port = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            data0     <= '0;
            data1     <= '0;
            rom_addr  <= '0;
            pend0     <= 1'b0;
            pend1     <= 1'b0;
            last_gnt  <= 1'b1;
            tag_valid <= '0;
            tag_owner <= '0;
        end else begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            tag_valid <= {tag_valid[ROM_LAT-1:0], gnt_any};
            tag_owner <= {tag_owner[ROM_LAT-1:0], gnt_port};

            if (gnt_any) begin
                rom_addr <= gnt_port ? addr1 : addr0;
                last_gnt <= gnt_port;
                if (gnt_port) begin
                    pend1 <= 1'b1;
                end else begin
                    pend0 <= 1'b1;
                end
            end

            // A grant requires pendN=0 and a return requires pendN=1, so a
            // grant and a return never collide on the same port. A cache hit
            // also requires pendN=0, so it never coincides with a ROM return
            // for the same port.
            if (ret_valid && !ret_owner) begin
                data0 <= rom_data;
                ack0  <= 1'b1;
                pend0 <= 1'b0;
            end
`ifdef FONT_ARB_CACHE_EN
            else if (hit0) begin
                data0 <= cdata0;
                ack0  <= 1'b1;
            end
`endif

            if (ret_valid && ret_owner) begin
                data1 <= rom_data;
                ack1  <= 1'b1;
                pend1 <= 1'b0;
            end
`ifdef FONT_ARB_CACHE_EN
            else if (hit1) begin
                data1 <= cdata1;
                ack1  <= 1'b1;
            end
`endif
        end
    end

`ifdef FONT_ARB_CACHE_EN
    // Only ROM returns refill the cache. A hit re-serves the entry as it is.
    always_ff @(posedge clk) begin
        if (rst) begin
            cvalid0 <= 1'b0;
            cvalid1 <= 1'b0;
            caddr0  <= '0;
            caddr1  <= '0;
            cdata0  <= '0;
            cdata1  <= '0;
            gaddr0  <= '0;
            gaddr1  <= '0;
        end else begin
            if (gnt_any && !gnt_port) begin
                gaddr0 <= addr0;
            end
            if (gnt_any && gnt_port) begin
                gaddr1 <= addr1;
            end
            if (ret_valid && !ret_owner) begin
                cvalid0 <= 1'b1;
                caddr0  <= gaddr0;
                cdata0  <= rom_data;
            end
            if (ret_valid && ret_owner) begin
                cvalid1 <= 1'b1;
                caddr1  <= gaddr1;
                cdata1  <= rom_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_font_rom_arbiter.sv
// ----------------------------------------------------------------------------
// tb_font_rom_arbiter
//
// Runs four arbiter instances with ROM_LAT = 1..4. Each instance has its own
// behavioural font_rom whose contents come from rom_fn(). Instance 0
// (ROM_LAT=1) carries the directed scenarios. All four take part in the
// randomized sweep. Inputs are driven and outputs sampled on the falling
// edge.
// ----------------------------------------------------------------------------
module tb_font_rom_arbiter;
    localparam int AW = 11;
    localparam int DW = 8;
    localparam int NI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req_v      [NI][2];
    logic [AW-1:0] addr_v     [NI][2];
    logic          ack_v      [NI][2];
    logic [DW-1:0] data_v     [NI][2];
    logic [AW-1:0] rom_addr_v [NI];
    logic [DW-1:0] rom_data_v [NI];

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        logic [15:0] t;
        t = {5'd0, a} * 16'd37 + 16'h005A;
        return t[7:0] ^ t[15:8];
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [AW-1:0] ap [4];

        font_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(g + 1)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .req0     (req_v[g][0]),
            .addr0    (addr_v[g][0]),
            .ack0     (ack_v[g][0]),
            .data0    (data_v[g][0]),
            .req1     (req_v[g][1]),
            .addr1    (addr_v[g][1]),
            .ack1     (ack_v[g][1]),
            .data1    (data_v[g][1]),
            .rom_addr (rom_addr_v[g]),
            .rom_data (rom_data_v[g])
        );

        // Registered ROM with a read latency of g+1 clocks.
        always @(posedge clk) begin
            ap[0] <= rom_addr_v[g];
            for (int i = 1; i < 4; i++) ap[i] <= ap[i-1];
        end
        assign rom_data_v[g] = rom_fn(ap[g]);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int l = 0; l < NI; l++) begin
            for (int p = 0; p < 2; p++) begin
                req_v[l][p] = 1'b0;
            end
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int l = 0; l < NI; l++) begin
            for (int p = 0; p < 2; p++) begin
                req_v[l][p]  = 1'b0;
                addr_v[l][p] = '0;
            end
        end
        rst = 1'b1;
        tick();
        tick();
        for (int l = 0; l < NI; l++) begin
            for (int p = 0; p < 2; p++) begin
                n_cmp++;
                if (ack_v[l][p] !== 1'b0) begin
                    n_err++;
                    $display("FAIL reset_ack inst%0d port%0d: got %b want 0", l, p, ack_v[l][p]);
                end
                n_cmp++;
                if (data_v[l][p] !== '0) begin
                    n_err++;
                    $display("FAIL reset_data inst%0d port%0d: got %h want 00", l, p, data_v[l][p]);
                end
            end
            n_cmp++;
            if (rom_addr_v[l] !== '0) begin
                n_err++;
                $display("FAIL reset_rom_addr inst%0d: got %h want 000", l, rom_addr_v[l]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req_v[0][0]  = 1'b1;
        addr_v[0][0] = 11'h1A3;
        for (int e = 1; e <= 5; e++) begin
            tick();
            if (e == 1) begin
                n_cmp++;
                if (rom_addr_v[0] !== 11'h1A3) begin
                    n_err++;
                    $display("FAIL single_rom_addr: got %h want 1a3", rom_addr_v[0]);
                end
            end
            n_cmp++;
            if (ack_v[0][0] !== (e == 3)) begin
                n_err++;
                $display("FAIL single_ack0 edge%0d: got %b want %b", e, ack_v[0][0], (e == 3));
            end
            n_cmp++;
            if (ack_v[0][1] !== 1'b0) begin
                n_err++;
                $display("FAIL single_ack1 edge%0d: got %b want 0", e, ack_v[0][1]);
            end
            if (e == 3) begin
                n_cmp++;
                if (data_v[0][0] !== rom_fn(11'h1A3)) begin
                    n_err++;
                    $display("FAIL single_data0: got %h want %h", data_v[0][0], rom_fn(11'h1A3));
                end
                req_v[0][0] = 1'b0;
            end
        end
    endtask

    task automatic test_contention();
        do_reset();
        req_v[0][0]  = 1'b1;
        addr_v[0][0] = 11'h010;
        req_v[0][1]  = 1'b1;
        addr_v[0][1] = 11'h020;
        for (int e = 1; e <= 5; e++) begin
            tick();
            if (e == 1 || e == 2) begin
                n_cmp++;
                if (rom_addr_v[0] !== ((e == 1) ? 11'h010 : 11'h020)) begin
                    n_err++;
                    $display("FAIL contention_rom_addr edge%0d: got %h want %h", e, rom_addr_v[0],
                             (e == 1) ? 11'h010 : 11'h020);
                end
            end
            n_cmp++;
            if (ack_v[0][0] !== (e == 3)) begin
                n_err++;
                $display("FAIL contention_ack0 edge%0d: got %b want %b", e, ack_v[0][0], (e == 3));
            end
            n_cmp++;
            if (ack_v[0][1] !== (e == 4)) begin
                n_err++;
                $display("FAIL contention_ack1 edge%0d: got %b want %b", e, ack_v[0][1], (e == 4));
            end
            if (e == 3) begin
                n_cmp++;
                if (data_v[0][0] !== rom_fn(11'h010)) begin
                    n_err++;
                    $display("FAIL contention_data0: got %h want %h", data_v[0][0], rom_fn(11'h010));
                end
                req_v[0][0] = 1'b0;
            end
            if (e == 4) begin
                n_cmp++;
                if (data_v[0][1] !== rom_fn(11'h020)) begin
                    n_err++;
                    $display("FAIL contention_data1: got %h want %h", data_v[0][1], rom_fn(11'h020));
                end
                req_v[0][1] = 1'b0;
            end
        end
    endtask

    // Both ports request continuously for 20 clocks. Each port moves to a
    // fresh address after every ack.
    task automatic test_fairness();
        int k[2];
        int last_own;
        k[0] = 0;
        k[1] = 0;
        last_own = -1;
        req_v[0][0]  = 1'b1;
        addr_v[0][0] = 11'h100;
        req_v[0][1]  = 1'b1;
        addr_v[0][1] = 11'h200;
        for (int e = 1; e <= 20; e++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (ack_v[0][p] === 1'b1) begin
                    n_cmp++;
                    if (data_v[0][p] !== rom_fn(addr_v[0][p])) begin
                        n_err++;
                        $display("FAIL fair_data port%0d edge%0d: got %h want %h", p, e, data_v[0][p],
                                 rom_fn(addr_v[0][p]));
                    end
                    n_cmp++;
                    if (last_own == p) begin
                        n_err++;
                        $display("FAIL fair_alternation edge%0d: got owner %0d twice, want other port", e, p);
                    end
                    last_own = p;
                    k[p]++;
                    addr_v[0][p] = addr_v[0][p] + 11'd1;
                end
            end
        end
        n_cmp++;
        if (k[0] < 6 || k[1] < 6 || k[0] - k[1] > 1 || k[1] - k[0] > 1) begin
            n_err++;
            $display("FAIL fair_counts: got ack0=%0d ack1=%0d want each >=6 and diff <=1", k[0], k[1]);
        end
        req_v[0][0] = 1'b0;
        req_v[0][1] = 1'b0;
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_reset_midflight();
        req_v[0][1]  = 1'b1;
        addr_v[0][1] = 11'h333;
        tick();
        n_cmp++;
        if (rom_addr_v[0] !== 11'h333) begin
            n_err++;
            $display("FAIL midrst_grant1: got %h want 333", rom_addr_v[0]);
        end
        rst = 1'b1;
        req_v[0][1] = 1'b0;
        tick();
        n_cmp++;
        if ({ack_v[0][0], ack_v[0][1], data_v[0][0], data_v[0][1], rom_addr_v[0]} !== '0) begin
            n_err++;
            $display("FAIL midrst_outputs: got ack0=%b ack1=%b d0=%h d1=%h ra=%h want all 0", ack_v[0][0],
                     ack_v[0][1], data_v[0][0], data_v[0][1], rom_addr_v[0]);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (ack_v[0][1] !== 1'b0 || ack_v[0][0] !== 1'b0) begin
                n_err++;
                $display("FAIL midrst_no_ack cycle%0d: got ack0=%b ack1=%b want 0 0", i, ack_v[0][0], ack_v[0][1]);
            end
        end
        req_v[0][0]  = 1'b1;
        addr_v[0][0] = 11'h044;
        req_v[0][1]  = 1'b1;
        addr_v[0][1] = 11'h088;
        tick();
        n_cmp++;
        if (rom_addr_v[0] !== 11'h044) begin
            n_err++;
            $display("FAIL midrst_first_contention: got %h want 044", rom_addr_v[0]);
        end
        req_v[0][0] = 1'b0;
        req_v[0][1] = 1'b0;
        for (int e = 2; e <= 4; e++) begin
            tick();
            n_cmp++;
            if (ack_v[0][0] !== (e == 3) || ack_v[0][1] !== 1'b0) begin
                n_err++;
                $display("FAIL midrst_ack edge%0d: got ack0=%b ack1=%b want %b 0", e, ack_v[0][0], ack_v[0][1],
                         (e == 3));
            end
        end
    endtask

    task automatic test_repeat();
        bit exp;
        do_reset();
        req_v[0][0]  = 1'b1;
        addr_v[0][0] = 11'h055;
        for (int e = 1; e <= 13; e++) begin
            tick();
`ifdef FONT_ARB_CACHE_EN
            exp = (e >= 3);
`else
            exp = (e % 3 == 0);
`endif
            n_cmp++;
            if (ack_v[0][0] !== exp) begin
                n_err++;
                $display("FAIL repeat_ack0 edge%0d: got %b want %b", e, ack_v[0][0], exp);
            end
            if (e >= 3) begin
                n_cmp++;
                if (data_v[0][0] !== rom_fn(11'h055)) begin
                    n_err++;
                    $display("FAIL repeat_data0 edge%0d: got %h want %h", e, data_v[0][0], rom_fn(11'h055));
                end
            end
            n_cmp++;
            if (rom_addr_v[0] !== 11'h055) begin
                n_err++;
                $display("FAIL repeat_rom_addr edge%0d: got %h want 055", e, rom_addr_v[0]);
            end
        end
        req_v[0][0] = 1'b0;
        for (int i = 0; i < 6; i++) tick();
    endtask

    // Reference model works at the transaction level. For each instance it
    // records which port owns a read, the cycle its ack is due, and the
    // expected data. Grants follow round-robin over the ports that need the
    // ROM.
    task automatic test_random_sweep();
        bit            m_pend [NI][2];
        int            m_due  [NI][2];
        logic [DW-1:0] m_data [NI][2];
        int            m_last [NI];
        logic [AW-1:0] m_rom  [NI];
`ifdef FONT_ARB_CACHE_EN
        logic [AW-1:0] m_gaddr [NI][2];
        bit            m_fromc [NI][2];
        bit            c_valid [NI][2];
        logic [AW-1:0] c_addr  [NI][2];
        logic [DW-1:0] c_data  [NI][2];
`endif
        bit  use_rom [2];
        bit  exp_ack;
        bit  drive;
        int  winner;
        do_reset();
        for (int l = 0; l < NI; l++) begin
            m_last[l] = 1;
            m_rom[l]  = '0;
            for (int p = 0; p < 2; p++) begin
                m_pend[l][p] = 1'b0;
                m_due[l][p]  = 0;
                m_data[l][p] = '0;
`ifdef FONT_ARB_CACHE_EN
                c_valid[l][p] = 1'b0;
                c_addr[l][p]  = '0;
                c_data[l][p]  = '0;
                m_gaddr[l][p] = '0;
                m_fromc[l][p] = 1'b0;
`endif
            end
        end
        for (int c = 0; c < 420; c++) begin
            if (c > 0) tick();
            drive = (c < 400);
            for (int l = 0; l < NI; l++) begin
                n_cmp++;
                if (rom_addr_v[l] !== m_rom[l]) begin
                    n_err++;
                    $display("FAIL sweep_rom_addr lat%0d cyc%0d: got %h want %h", l + 1, c, rom_addr_v[l], m_rom[l]);
                end
                for (int p = 0; p < 2; p++) begin
                    exp_ack = m_pend[l][p] && (m_due[l][p] == c);
                    n_cmp++;
                    if (ack_v[l][p] !== exp_ack) begin
                        n_err++;
                        $display("FAIL sweep_ack lat%0d port%0d cyc%0d: got %b want %b", l + 1, p, c, ack_v[l][p],
                                 exp_ack);
                    end
                    if (exp_ack) begin
                        n_cmp++;
                        if (data_v[l][p] !== m_data[l][p]) begin
                            n_err++;
                            $display("FAIL sweep_data lat%0d port%0d cyc%0d: got %h want %h", l + 1, p, c,
                                     data_v[l][p], m_data[l][p]);
                        end
                        m_pend[l][p] = 1'b0;
`ifdef FONT_ARB_CACHE_EN
                        if (!m_fromc[l][p]) begin
                            c_valid[l][p] = 1'b1;
                            c_addr[l][p]  = m_gaddr[l][p];
                            c_data[l][p]  = m_data[l][p];
                        end
`endif
                    end
                    // Requester behaviour: addr changes only while idle or in the ack cycle.
                    if (!drive) begin
                        req_v[l][p] = 1'b0;
                    end else if (exp_ack) begin
                        if ($urandom_range(0, 1) == 1) begin
                            req_v[l][p]  = 1'b1;
                            addr_v[l][p] = AW'($urandom_range(0, 11) * 97);
                        end else begin
                            req_v[l][p] = 1'b0;
                        end
                    end else if (!req_v[l][p] && !m_pend[l][p]) begin
                        if ($urandom_range(0, 2) == 0) begin
                            req_v[l][p]  = 1'b1;
                            addr_v[l][p] = AW'($urandom_range(0, 11) * 97);
                        end
                    end else if (req_v[l][p] && m_pend[l][p] && $urandom_range(0, 15) == 0) begin
                        req_v[l][p] = 1'b0;
                    end
                end
                // Predict what the next edge does.
                for (int p = 0; p < 2; p++) begin
                    use_rom[p] = req_v[l][p] && !m_pend[l][p];
`ifdef FONT_ARB_CACHE_EN
                    if (use_rom[p] && c_valid[l][p] && addr_v[l][p] == c_addr[l][p]) begin
                        use_rom[p]    = 1'b0;
                        m_pend[l][p]  = 1'b1;
                        m_due[l][p]   = c + 1;
                        m_data[l][p]  = c_data[l][p];
                        m_fromc[l][p] = 1'b1;
                    end
`endif
                end
                winner = -1;
                if (use_rom[0] && use_rom[1]) winner = 1 - m_last[l];
                else if (use_rom[0]) winner = 0;
                else if (use_rom[1]) winner = 1;
                if (winner >= 0) begin
                    m_pend[l][winner] = 1'b1;
                    m_due[l][winner]  = c + 1 + (l + 1) + 1;
                    m_data[l][winner] = rom_fn(addr_v[l][winner]);
                    m_last[l]         = winner;
                    m_rom[l]          = addr_v[l][winner];
`ifdef FONT_ARB_CACHE_EN
                    m_gaddr[l][winner] = addr_v[l][winner];
                    m_fromc[l][winner] = 1'b0;
`endif
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int l = 0; l < NI; l++) begin
            for (int p = 0; p < 2; p++) begin
                req_v[l][p]  = 1'b0;
                addr_v[l][p] = '0;
            end
        end
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_reset_midflight();
        test_repeat();
        test_random_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
